// File: rtl/hamming_decoder_pkg.sv
// Shared definitions for the SECDED Hamming(15,11)+parity decoder.
package hamming_decoder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StCapt,
    StFix,
    StWrLo,
    StWrHi,
    StDone
  } dec_state_t;

  localparam logic [1:0] kFLAG_OK   = 2'b00;
  localparam logic [1:0] kFLAG_1ERR = 2'b01;
  localparam logic [1:0] kFLAG_2ERR = 2'b10;

  localparam int unsigned kPOS_P1 = 1;
  localparam int unsigned kPOS_P2 = 2;
  localparam int unsigned kPOS_P4 = 4;
  localparam int unsigned kPOS_P8 = 8;

endpackage

// File: rtl/hamming_decoder_syndrome.sv
// Combinational SECDED check: syndrome, overall parity, corrected data and flag.
module hamming_decoder_syndrome
  import hamming_decoder_pkg::*;
(
  input  logic [15:0] codeword_i,
  output logic [3:0]  syndrome_o,
  output logic        parity_o,
  output logic [10:0] data_o,
  output logic [1:0]  flag_o
);

  logic [15:0] corrected;

  always_comb begin
    syndrome_o = 4'd0;
    for (int i = kPOS_P1; i < 16; i++) begin
      if (codeword_i[i]) syndrome_o = syndrome_o ^ 4'(i);
    end
  end

  assign parity_o = ^codeword_i;

  // Odd overall parity means exactly one flipped bit; syndrome 0 then points at p16.
  assign corrected = parity_o ? (codeword_i ^ (16'd1 << syndrome_o)) : codeword_i;

  assign data_o = {corrected[15:kPOS_P8+1], corrected[kPOS_P8-1:kPOS_P4+1],
                   corrected[kPOS_P2+1]};

  always_comb begin
    if (parity_o) begin
      flag_o = kFLAG_1ERR;
    end else if (syndrome_o != 4'd0) begin
      flag_o = kFLAG_2ERR;
    end else begin
      flag_o = kFLAG_OK;
    end
  end

endmodule

// File: rtl/hamming_decoder.sv
// Sequencer that reads encoded words from memory, runs SECDED and writes decoded words back.
module hamming_decoder
  import hamming_decoder_pkg::*;
#(
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned DST_BASE  = 0,
  parameter int unsigned NUM_WORDS = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       busy_o,
  output logic [7:0] mem_addr_o,
  output logic       mem_rd_en_o,
  input  logic [7:0] mem_rdata_i,
  output logic       mem_wr_en_o,
  output logic [7:0] mem_wdata_o,
  output logic [7:0] err1_cnt_o,
  output logic [7:0] err2_cnt_o
);

  localparam logic [7:0] SrcBase = 8'(SRC_BASE);
  localparam logic [7:0] DstBase = 8'(DST_BASE);
  localparam logic [5:0] LastK   = 6'(NUM_WORDS - 1);

  dec_state_t  state_q;
  logic [5:0]  k_q;
  logic [15:0] cw_q;
  logic [2:0]  data_hi_q;
  logic [1:0]  flag_q;
  logic        done_q, busy_q, rd_en_q, wr_en_q;
  logic [7:0]  addr_q, wdata_q, err1_q, err2_q;

  logic [3:0]  syndrome;
  logic        parity;
  logic [10:0] fix_data;
  logic [1:0]  fix_flag;
  logic [7:0]  k_off, k_off_next;

  assign k_off      = {1'b0, k_q, 1'b0};
  assign k_off_next = {1'b0, k_q + 6'd1, 1'b0};

  hamming_decoder_syndrome u_syndrome (
    .codeword_i (cw_q),
    .syndrome_o (syndrome),
    .parity_o   (parity),
    .data_o     (fix_data),
    .flag_o     (fix_flag)
  );

  // Outputs are registered alongside the state so they are valid for the whole state cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      k_q       <= 6'd0;
      cw_q      <= 16'd0;
      data_hi_q <= 3'd0;
      flag_q    <= kFLAG_OK;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      err1_q    <= 8'd0;
      err2_q    <= 8'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            k_q     <= 6'd0;
            err1_q  <= 8'd0;
            err2_q  <= 8'd0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            addr_q  <= SrcBase;
            state_q <= StRdLo;
          end
        end
        StRdLo: begin
          addr_q  <= SrcBase + k_off + 8'd1;
          state_q <= StRdHi;
        end
        StRdHi: begin
          cw_q[7:0] <= mem_rdata_i;
          rd_en_q   <= 1'b0;
          state_q   <= StCapt;
        end
        StCapt: begin
          cw_q[15:8] <= mem_rdata_i;
          state_q    <= StFix;
        end
        StFix: begin
          data_hi_q <= fix_data[10:8];
          flag_q    <= fix_flag;
          if (parity && err1_q != 8'hFF) err1_q <= err1_q + 8'd1;
          if (!parity && syndrome != 4'd0 && err2_q != 8'hFF) err2_q <= err2_q + 8'd1;
          wr_en_q   <= 1'b1;
          addr_q    <= DstBase + k_off;
          wdata_q   <= fix_data[7:0];
          state_q   <= StWrLo;
        end
        StWrLo: begin
          addr_q  <= DstBase + k_off + 8'd1;
          wdata_q <= {flag_q, 3'b000, data_hi_q};
          state_q <= StWrHi;
        end
        StWrHi: begin
          wr_en_q <= 1'b0;
          if (k_q == LastK) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            k_q     <= k_q + 6'd1;
            rd_en_q <= 1'b1;
            addr_q  <= SrcBase + k_off_next;
            state_q <= StRdLo;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = addr_q;
  assign mem_rd_en_o = rd_en_q;
  assign mem_wr_en_o = wr_en_q;
  assign mem_wdata_o = wdata_q;
  assign err1_cnt_o  = err1_q;
  assign err2_cnt_o  = err2_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench: directed single-word cases plus randomized 15-word passes vs a SECDED model.
module tb_hamming_decoder;

  logic clk, rst;
  int   checks, failures;

  // One-word DUT for directed cases, fifteen-word DUT for randomized passes.
  logic       start1, done1, busy1, rd1, wr1;
  logic [7:0] addr1, rdata1, wd1, e1_1, e2_1;
  logic       start15, done15, busy15, rd15, wr15;
  logic [7:0] addr15, rdata15, wd15, e1_15, e2_15;

  logic [7:0] mem1  [256];
  logic [7:0] mem15 [256];
  logic       ld_en, ld_sel;
  logic [7:0] ld_addr, ld_data;

  logic [7:0] exp_lo [15];
  logic [7:0] exp_hi [15];
  int         exp_e1, exp_e2;

  hamming_decoder #(.SRC_BASE(30), .DST_BASE(0), .NUM_WORDS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .done_o(done1), .busy_o(busy1),
    .mem_addr_o(addr1), .mem_rd_en_o(rd1), .mem_rdata_i(rdata1), .mem_wr_en_o(wr1),
    .mem_wdata_o(wd1), .err1_cnt_o(e1_1), .err2_cnt_o(e2_1)
  );

  hamming_decoder dut15 (
    .clk_i(clk), .rst_i(rst), .start_i(start15), .done_o(done15), .busy_o(busy15),
    .mem_addr_o(addr15), .mem_rd_en_o(rd15), .mem_rdata_i(rdata15), .mem_wr_en_o(wr15),
    .mem_wdata_o(wd15), .err1_cnt_o(e1_15), .err2_cnt_o(e2_15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd1) rdata1 <= mem1[addr1];
    if (wr1) mem1[addr1] <= wd1;
    else if (ld_en && !ld_sel) mem1[ld_addr] <= ld_data;
    if (rd15) rdata15 <= mem15[addr15];
    if (wr15) mem15[addr15] <= wd15;
    else if (ld_en && ld_sel) mem15[ld_addr] <= ld_data;
  end

  always @(negedge clk) begin
    if (rd1 || wr1 || rd15 || wr15) begin
      checks++;
      if ((rd1 && wr1) || (rd15 && wr15)) begin
        failures++;
        $display("FAIL rd_wr_overlap: got rd1=%0b wr1=%0b rd15=%0b wr15=%0b, want no overlap",
                 rd1, wr1, rd15, wr15);
      end
    end
  end

  // Reference encoder: data bits fill non-power-of-two positions 3,5,6,7,9..15 in order.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int j;
    c = 16'd0;
    j = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      logic x;
      x = 1'b0;
      for (int q = 1; q < 16; q++) if (((q >> b) & 1) == 1 && q != (1 << b)) x = x ^ c[q];
      c[1 << b] = x;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int j;
    d = 11'd0;
    j = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    end
    return d;
  endfunction

  task automatic poke(input logic sel, input logic [7:0] a, input logic [7:0] v);
    ld_sel  = sel;
    ld_addr = a;
    ld_data = v;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Fills mem15 with random words carrying 0, 1 or 2 injected errors and records expectations.
  task automatic prepare15();
    exp_e1 = 0;
    exp_e2 = 0;
    for (int k = 0; k < 15; k++) begin
      logic [10:0] d, od;
      logic [15:0] c;
      logic [1:0]  f;
      int kind, p, q;
      d    = 11'($urandom);
      c    = encode(d);
      kind = (k < 3) ? k : int'($urandom_range(0, 2));
      p    = int'($urandom_range(0, 15));
      q    = (p + int'($urandom_range(1, 15))) % 16;
      if (kind == 0) begin
        f  = 2'b00;
        od = d;
      end else if (kind == 1) begin
        c[p] = ~c[p];
        f    = 2'b01;
        od   = d;
        exp_e1++;
      end else begin
        c[p] = ~c[p];
        c[q] = ~c[q];
        f    = 2'b10;
        od   = extract(c);
        exp_e2++;
      end
      exp_lo[k] = od[7:0];
      exp_hi[k] = {f, 3'b000, od[10:8]};
      poke(1'b1, 8'(30 + 2 * k), c[7:0]);
      poke(1'b1, 8'(31 + 2 * k), c[15:8]);
      poke(1'b1, 8'(2 * k), 8'hA5);
      poke(1'b1, 8'(2 * k + 1), 8'hA5);
    end
  endtask

  task automatic run1(output int cyc);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!done1) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({done1, busy1, rd1, wr1, addr1, wd1, e1_1, e2_1} !== 36'd0) begin
      failures++;
      $display("FAIL reset_dut1: got %h, want 0", {done1, busy1, rd1, wr1, addr1, wd1, e1_1, e2_1});
    end
    checks++;
    if ({done15, busy15, rd15, wr15, addr15, wd15, e1_15, e2_15} !== 36'd0) begin
      failures++;
      $display("FAIL reset_dut15: got %h, want 0",
               {done15, busy15, rd15, wr15, addr15, wd15, e1_15, e2_15});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    logic [7:0] tbl [6][6];
    int cyc;
    tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'd0, 8'd0};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'h07, 8'd0, 8'd0};
    tbl[2] = '{8'hDF, 8'hFF, 8'hFF, 8'h47, 8'd1, 8'd0};
    tbl[3] = '{8'hFE, 8'hFF, 8'hFF, 8'h47, 8'd1, 8'd0};
    tbl[4] = '{8'hF9, 8'hFF, 8'hFF, 8'h87, 8'd0, 8'd1};
    tbl[5] = '{8'h08, 8'h00, 8'h00, 8'h40, 8'd1, 8'd0};
    for (int i = 0; i < 6; i++) begin
      poke(1'b0, 8'd30, tbl[i][0]);
      poke(1'b0, 8'd31, tbl[i][1]);
      poke(1'b0, 8'd0, 8'h5A);
      poke(1'b0, 8'd1, 8'h5A);
      run1(cyc);
      checks++;
      if (cyc != 7) begin
        failures++;
        $display("FAIL single_done_cycle[%0d]: got %0d, want 7", i, cyc);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL single_idle[%0d]: got done=%0b busy=%0b, want 0 0", i, done1, busy1);
      end
      checks++;
      if ({mem1[1], mem1[0]} !== {tbl[i][3], tbl[i][2]}) begin
        failures++;
        $display("FAIL single_data[%0d]: got %h, want %h", i, {mem1[1], mem1[0]},
                 {tbl[i][3], tbl[i][2]});
      end
      checks++;
      if (e1_1 !== tbl[i][4] || e2_1 !== tbl[i][5]) begin
        failures++;
        $display("FAIL single_counts[%0d]: got %0d/%0d, want %0d/%0d", i, e1_1, e2_1,
                 tbl[i][4], tbl[i][5]);
      end
    end
  endtask

  // Full 15-word pass with Start pulses sprinkled while busy; they must be ignored.
  task automatic test_full_pass(input string tag);
    int cyc;
    prepare15();
    @(negedge clk);
    start15 = 1'b1;
    @(negedge clk);
    start15 = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (done15) break;
      @(negedge clk);
      cyc++;
      start15 = ((cyc % 17) == 5) && !done15;
    end
    start15 = 1'b0;
    checks++;
    if (!done15 || cyc != 91) begin
      failures++;
      $display("FAIL %s_done_cycle: got %0d (done=%0b), want 91", tag, cyc, done15);
    end
    @(negedge clk);
    checks++;
    if (done15 !== 1'b0 || busy15 !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: got done=%0b busy=%0b, want 0 0", tag, done15, busy15);
    end
    for (int k = 0; k < 15; k++) begin
      checks++;
      if ({mem15[2 * k + 1], mem15[2 * k]} !== {exp_hi[k], exp_lo[k]}) begin
        failures++;
        $display("FAIL %s_word[%0d]: got %h, want %h", tag, k, {mem15[2 * k + 1], mem15[2 * k]},
                 {exp_hi[k], exp_lo[k]});
      end
    end
    checks++;
    if (e1_15 !== 8'(exp_e1) || e2_15 !== 8'(exp_e2)) begin
      failures++;
      $display("FAIL %s_counts: got %0d/%0d, want %0d/%0d", tag, e1_15, e2_15, exp_e1, exp_e2);
    end
  endtask

  task automatic test_abort_reset();
    int cyc;
    bit saw_bad;
    prepare15();
    @(negedge clk);
    start15 = 1'b1;
    @(negedge clk);
    start15 = 1'b0;
    cyc = 1;
    while (cyc < 23) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (wr15 !== 1'b1 || addr15 !== 8'd6) begin
      failures++;
      $display("FAIL abort_wrlo: got wr=%0b addr=%0d, want 1 6", wr15, addr15);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({done15, busy15, rd15, wr15, addr15, wd15, e1_15, e2_15} !== 36'd0) begin
      failures++;
      $display("FAIL abort_outputs: got %h, want 0",
               {done15, busy15, rd15, wr15, addr15, wd15, e1_15, e2_15});
    end
    saw_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done15 || wr15 || busy15) saw_bad = 1'b1;
    end
    checks++;
    if (saw_bad) begin
      failures++;
      $display("FAIL abort_quiet: got activity after reset, want none");
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({mem15[2 * k + 1], mem15[2 * k]} !== {exp_hi[k], exp_lo[k]}) begin
        failures++;
        $display("FAIL abort_word[%0d]: got %h, want %h", k, {mem15[2 * k + 1], mem15[2 * k]},
                 {exp_hi[k], exp_lo[k]});
      end
    end
    for (int a = 7; a < 30; a++) begin
      checks++;
      if (mem15[a] !== 8'hA5) begin
        failures++;
        $display("FAIL abort_untouched[%0d]: got %h, want a5", a, mem15[a]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start1   = 1'b0;
    start15  = 1'b0;
    ld_en    = 1'b0;
    ld_sel   = 1'b0;
    ld_addr  = 8'd0;
    ld_data  = 8'd0;
    test_reset();
    test_single_word();
    test_full_pass("pass_a");
    test_full_pass("pass_b");
    test_abort_reset();
    test_full_pass("after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
